wb_nfc_host_queue: RTL and testbench

- Parametrised Wishbone slave front-end for the NAND flash controller (NFC).
- Maps the dual-port page buffer and a control register bank onto one Wishbone slave port.
- Adds a CMD_DEPTH-deep command queue of {command, page address} pairs, so the host can post several operations back to back.
- A launch FSM drains the queue into the NFC one command at a time. Per-command and sticky error status are kept, and a full-queue write is reported with wb_err_o.

---
 rtl/wb_nfc_host_queue_if.sv | 25 ++
 rtl/wb_nfc_host_queue.sv | 259 +++++++++++++++++++++++++
 tb/tb_wb_nfc_host_queue.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_nfc_host_queue_if.sv
// Wishbone slave bus bundle for the NFC host queue.
// Signal names keep the slave-side _i/_o suffixes of the bus.
interface wb_nfc_host_queue_if #(
    parameter int WB_AW = 16,
    parameter int WB_DW = 32
);
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic [WB_AW-1:0] wb_adr_i;
    logic [WB_DW-1:0] wb_dat_i;
    logic [WB_DW-1:0] wb_dat_o;
    logic             wb_ack_o;
    logic             wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_nfc_host_queue.sv
// Wishbone front-end for the NFC: page buffer window, register bank,
// command queue and launch FSM. Optional IRQ block under NFC_IRQ_EN.
module wb_nfc_host_queue #(
    parameter int WB_AW     = 16,
    parameter int WB_DW     = 32,
    parameter int BUF_AW    = 11,
    parameter int BUF_DW    = 8,
    parameter int ROW_AW    = 17,
    parameter int CMD_W     = 3,
    parameter int CMD_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_nfc_host_queue_if.slave wb,
    input  logic [BUF_DW-1:0] bf_dout,
    output logic [BUF_DW-1:0] bf_din,
    output logic [BUF_AW-1:0] bf_ad,
    output logic              bf_we,
    output logic              bf_sel,
    output logic              nfc_strt,
    input  logic              nfc_done,
    output logic [CMD_W-1:0]  nfc_cmd,
    output logic [ROW_AW-1:0] page_address,
    input  logic              perr,
    input  logic              eerr,
    input  logic              rerr
`ifdef NFC_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int QA = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(CMD_DEPTH + 1);

    localparam logic [WB_AW-1:0] A_ROW  = WB_AW'(2 ** BUF_AW);
    localparam logic [WB_AW-1:0] A_CMD  = A_ROW + WB_AW'(1);
    localparam logic [WB_AW-1:0] A_STAT = A_ROW + WB_AW'(2);
    localparam logic [WB_AW-1:0] A_ERR  = A_ROW + WB_AW'(3);
    localparam logic [WB_AW-1:0] A_IRQ  = A_ROW + WB_AW'(4);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } state_t;

    state_t state;

    logic              req;
    logic              wr;
    logic              in_win;
    logic              is_row;
    logic              is_cmd;
    logic              is_err;
    logic              is_irq;
    logic              push;
    logic              ovf;
    logic              pop;
    logic              full;
    logic              done_ev;

    logic [ROW_AW-1:0] row_addr;
    logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
    logic [ROW_AW-1:0] row_mem [CMD_DEPTH];
    logic [QA-1:0]     wr_ptr;
    logic [QA-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push_pend;

    logic [2:0]        last_err;
    logic [2:0]        sticky;

    logic              buf_rsp;
    logic [WB_DW-1:0]  rdata_q;
    logic [WB_DW-1:0]  rd_val;
    logic [WB_DW-1:0]  buf_ext;

`ifdef NFC_IRQ_EN
    logic [1:0]        irq_en;
    logic              done_pend;
`endif

    assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o;
    assign wr     = req & wb.wb_we_i;
    assign in_win = wb.wb_adr_i < A_ROW;
    assign is_row = wb.wb_adr_i == A_ROW;
    assign is_cmd = wb.wb_adr_i == A_CMD;
    assign is_err = wb.wb_adr_i == A_ERR;
    assign is_irq = wb.wb_adr_i == A_IRQ;

    assign full    = count == CW'(CMD_DEPTH);
    assign push    = wr & is_cmd & ~full;
    assign ovf     = wr & is_cmd & full;
    assign pop     = (state == IDLE) && (count != '0);
    assign done_ev = (state == WAIT_DONE) & nfc_done;

    assign bf_sel = req & in_win;
    assign bf_we  = bf_sel & wb.wb_we_i;
    assign bf_ad  = wb.wb_adr_i[BUF_AW-1:0];
    assign bf_din = wb.wb_dat_i[BUF_DW-1:0];

    // Zero-extend buffer read data onto the bus width.
    always_comb begin
        buf_ext = '0;
        buf_ext[BUF_DW-1:0] = bf_dout;
    end

    assign wb.wb_dat_o = buf_rsp ? buf_ext : rdata_q;

    // Register read multiplexer; unmapped addresses read 0.
    always_comb begin
        rd_val = '0;
        if (is_row) begin
            rd_val[ROW_AW-1:0] = row_addr;
        end else if (wb.wb_adr_i == A_STAT) begin
            rd_val[0]      = (state == IDLE) && (count == '0);
            rd_val[1]      = state != IDLE;
            rd_val[2]      = full;
            rd_val[8 +: CW] = count;
        end else if (is_err) begin
            rd_val[2:0] = last_err;
            rd_val[6:4] = sticky;
`ifdef NFC_IRQ_EN
        end else if (is_irq) begin
            rd_val[1:0] = irq_en;
            rd_val[8]   = done_pend;
`endif
        end
    end

    // Single-cycle ack/err response and registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            buf_rsp     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wb.wb_ack_o <= req & ~ovf;
            wb.wb_err_o <= ovf;
            buf_rsp     <= req & in_win & ~wb.wb_we_i;
            rdata_q     <= (req & ~in_win & ~wb.wb_we_i) ? rd_val : '0;
        end
    end

    // Staging page address register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_addr <= '0;
        end else if (wr & is_row) begin
            row_addr <= wb.wb_dat_i[ROW_AW-1:0];
        end
    end

    // Command queue: entry written on the request, made visible one cycle
    // later so the launch lines up with the response cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cmd_mem[i] <= '0;
                row_mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            push_pend <= 1'b0;
        end else begin
            push_pend <= push;
            if (push) begin
                cmd_mem[wr_ptr] <= wb.wb_dat_i[CMD_W-1:0];
                row_mem[wr_ptr] <= row_addr;
            end
            if (push_pend) begin
                wr_ptr <= wr_ptr + QA'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + QA'(1);
            end
            if (push_pend && !pop) begin
                count <= count + CW'(1);
            end else if (!push_pend && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Launch FSM: pop one command, strobe the NFC, wait for completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            nfc_strt     <= 1'b0;
            nfc_cmd      <= '1;
            page_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    nfc_strt <= 1'b0;
                    if (pop) begin
                        nfc_cmd      <= cmd_mem[rd_ptr];
                        page_address <= row_mem[rd_ptr];
                        nfc_strt     <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    nfc_strt <= 1'b0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    nfc_strt <= 1'b0;
                    if (nfc_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    nfc_strt <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Error status: last completion plus sticky OR; a new error beats a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_err <= '0;
            sticky   <= '0;
        end else begin
            if (done_ev) begin
                last_err <= {perr, eerr, rerr};
            end
            sticky <= (sticky & ~((wr & is_err) ? wb.wb_dat_i[6:4] : 3'b000))
                    | (done_ev ? {perr, eerr, rerr} : 3'b000);
        end
    end

`ifdef NFC_IRQ_EN
    // Interrupt enables, done-pending flag and registered irq line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en    <= '0;
            done_pend <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr & is_irq) begin
                irq_en <= wb.wb_dat_i[1:0];
            end
            done_pend <= done_ev
                       | (done_pend & ~(wr & is_irq & wb.wb_dat_i[8]));
            irq <= (done_pend & irq_en[0]) | ((|sticky) & irq_en[1]);
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{wb.wb_dat_i, is_irq};

endmodule

// File: tb/tb_wb_nfc_host_queue.sv
// Scoreboard bench for wb_nfc_host_queue: bus responses and NFC strobes
// are checked by monitors against queued expectations.
module tb_wb_nfc_host_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bf_dout;
    logic [7:0]  bf_din;
    logic [10:0] bf_ad;
    logic        bf_we;
    logic        bf_sel;
    logic        nfc_strt;
    logic        nfc_done;
    logic [2:0]  nfc_cmd;
    logic [16:0] page_address;
    logic        perr, eerr, rerr;
`ifdef NFC_IRQ_EN
    logic        irq;
`endif

    wb_nfc_host_queue_if #(.WB_AW(16), .WB_DW(32)) wbi ();

    wb_nfc_host_queue dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wb           (wbi),
        .bf_dout      (bf_dout),
        .bf_din       (bf_din),
        .bf_ad        (bf_ad),
        .bf_we        (bf_we),
        .bf_sel       (bf_sel),
        .nfc_strt     (nfc_strt),
        .nfc_done     (nfc_done),
        .nfc_cmd      (nfc_cmd),
        .page_address (page_address),
        .perr         (perr),
        .eerr         (eerr),
        .rerr         (rerr)
`ifdef NFC_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [15:0] ROW  = 16'h0800;
    localparam logic [15:0] CMD  = 16'h0801;
    localparam logic [15:0] STAT = 16'h0802;
    localparam logic [15:0] ERR  = 16'h0803;
    localparam logic [15:0] IRQR = 16'h0804;

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] dat;
    } rsp_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [16:0] row;
    } stb_t;

    rsp_t rsp_q[$];
    stb_t stb_q[$];
    rsp_t mon_r;
    stb_t mon_s;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [10:0] we_ad;
    bit prev_rsp = 0;
    int lat;

    // Page buffer model with synchronous read.
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (bf_sel) begin
            if (bf_we) mem[bf_ad] <= bf_din;
            bf_dout <= mem[bf_ad];
        end
    end

    always @(negedge clk) begin
        if (bf_we) begin
            we_cnt++;
            we_ad = bf_ad;
        end
    end

    // Bus response monitor.
    always @(negedge clk) begin
        if (wbi.wb_ack_o | wbi.wb_err_o) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected ack=%b err=%b", wbi.wb_ack_o, wbi.wb_err_o);
            end else begin
                mon_r = rsp_q.pop_front();
                if (wbi.wb_err_o !== mon_r.err || wbi.wb_ack_o !== !mon_r.err
                    || prev_rsp || (mon_r.chk && wbi.wb_dat_o !== mon_r.dat)) begin
                    errors++;
                    $display("FAIL wb_rsp ack=%b err=%b dat=%h back2back=%b want err=%b dat=%h",
                             wbi.wb_ack_o, wbi.wb_err_o, wbi.wb_dat_o, prev_rsp,
                             mon_r.err, mon_r.dat);
                end
            end
        end
        prev_rsp = wbi.wb_ack_o | wbi.wb_err_o;
    end

    // NFC strobe monitor.
    always @(negedge clk) begin
        if (nfc_strt) begin
            checks++;
            if (stb_q.size() == 0) begin
                errors++;
                $display("FAIL strt_unexpected cmd=%h row=%h", nfc_cmd, page_address);
            end else begin
                mon_s = stb_q.pop_front();
                if (nfc_cmd !== mon_s.cmd || page_address !== mon_s.row) begin
                    errors++;
                    $display("FAIL strt cmd=%h row=%h want cmd=%h row=%h",
                             nfc_cmd, page_address, mon_s.cmd, mon_s.row);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input bit we, input logic [15:0] adr, input logic [31:0] dat,
                           input bit exp_err, input bit chkd, input logic [31:0] exp_dat);
        rsp_t e;
        bit got;
        e.err = exp_err;
        e.chk = chkd;
        e.dat = exp_dat;
        rsp_q.push_back(e);
        @(posedge clk);
        #1;
        wbi.wb_cyc_i = 1'b1;
        wbi.wb_stb_i = 1'b1;
        wbi.wb_we_i  = we;
        wbi.wb_adr_i = adr;
        wbi.wb_dat_i = dat;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (wbi.wb_ack_o | wbi.wb_err_o) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wb_timeout adr=%h", adr);
        end
        wbi.wb_cyc_i = 1'b0;
        wbi.wb_stb_i = 1'b0;
        wbi.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [15:0] adr, input logic [31:0] dat);
        wb_xfer(1'b1, adr, dat, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [15:0] adr, input logic [31:0] exp);
        wb_xfer(1'b0, adr, 32'h0, 1'b0, 1'b1, exp);
    endtask

    task automatic post(input logic [16:0] row, input logic [2:0] cmd, input bit launches);
        stb_t s;
        wr(ROW, {15'h0, row});
        if (launches) begin
            s.cmd = cmd;
            s.row = row;
            stb_q.push_back(s);
        end
        wr(CMD, {29'h0, cmd});
    endtask

    task automatic wait_strt(output int l);
        bit got;
        got = 0;
        l = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nfc_strt) begin
                got = 1;
                l = i;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL strt_timeout");
        end
    endtask

    task automatic pulse_done(input logic p, input logic e, input logic r);
        @(posedge clk);
        #1;
        nfc_done = 1'b1;
        perr = p;
        eerr = e;
        rerr = r;
        @(posedge clk);
        #1;
        nfc_done = 1'b0;
        perr = 1'b0;
        eerr = 1'b0;
        rerr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wbi.wb_cyc_i = 1'b0;
        wbi.wb_stb_i = 1'b0;
        wbi.wb_we_i  = 1'b0;
        wbi.wb_adr_i = '0;
        wbi.wb_dat_i = '0;
        nfc_done = 1'b0;
        perr = 1'b0;
        eerr = 1'b0;
        rerr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, wbi.wb_ack_o}, 32'h0);
        chk("rst_err", {31'h0, wbi.wb_err_o}, 32'h0);
        chk("rst_dat", wbi.wb_dat_o, 32'h0);
        chk("rst_cmd", {29'h0, nfc_cmd}, 32'h7);
        chk("rst_row", {15'h0, page_address}, 32'h0);
        chk("rst_strt", {31'h0, nfc_strt}, 32'h0);
`ifdef NFC_IRQ_EN
        chk("rst_irq", {31'h0, irq}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        rd(STAT, 32'h0000_0001);

        // Single command with latency checks.
        post(17'h12345, 3'd2, 1'b1);
        wait_strt(lat);
        chk("lat_rsp_strt", lat, 2);
        rd(ROW, 32'h0001_2345);
        rd(STAT, 32'h0000_0002);
        pulse_done(1'b0, 1'b0, 1'b0);
        rd(STAT, 32'h0000_0001);

        // Fill the queue while the NFC is busy.
        post(17'h00100, 3'd1, 1'b1);
        wait_strt(lat);
        post(17'h00200, 3'd3, 1'b1);
        post(17'h00300, 3'd4, 1'b1);
        post(17'h1FFFF, 3'd5, 1'b1);
        post(17'h00000, 3'd6, 1'b1);
        wr(ROW, 32'h0000_001F);
        wb_xfer(1'b1, CMD, 32'h0, 1'b1, 1'b0, 32'h0);
        rd(STAT, 32'h0000_0406);
        rd(ROW, 32'h0000_001F);

        // Drain with one program error first.
        pulse_done(1'b1, 1'b0, 1'b0);
        wait_strt(lat);
        chk("lat_done_strt", lat, 1);
        rd(ERR, 32'h0000_0044);
        pulse_done(1'b0, 1'b0, 1'b0);
        wait_strt(lat);
        pulse_done(1'b0, 1'b0, 1'b0);
        wait_strt(lat);
        pulse_done(1'b0, 1'b0, 1'b0);
        wait_strt(lat);
        pulse_done(1'b0, 1'b0, 1'b0);
        rd(STAT, 32'h0000_0001);
        rd(ERR, 32'h0000_0040);
        wr(ERR, 32'h0000_0040);
        rd(ERR, 32'h0000_0000);

        // nfc_done while idle must not touch error state.
        pulse_done(1'b1, 1'b1, 1'b1);
        rd(ERR, 32'h0000_0000);

        // Buffer window write and readback at the top address.
        wr(16'h07FF, 32'h0000_00A5);
        chk("bf_we_cnt", we_cnt, 1);
        chk("bf_ad", {21'h0, we_ad}, 32'h0000_07FF);
        rd(16'h07FF, 32'h0000_00A5);

        // Unmapped and IRQ slots read 0.
        wr(16'h0805, 32'hFFFF_FFFF);
        rd(16'h0805, 32'h0);
        rd(IRQR, 32'h0);

        // Reset while waiting with two commands queued.
        post(17'h00AAA, 3'd1, 1'b1);
        wait_strt(lat);
        post(17'h00BBB, 3'd2, 1'b0);
        post(17'h00CCC, 3'd3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_cmd", {29'h0, nfc_cmd}, 32'h7);
        rd(STAT, 32'h0000_0001);
        pulse_done(1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        rd(ERR, 32'h0000_0000);
        rd(STAT, 32'h0000_0001);

        repeat (4) @(posedge clk);
        chk("rsp_q_empty", rsp_q.size(), 0);
        chk("stb_q_empty", stb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
